// File: rtl/sb_cfg_loader.sv
// Daisy-chained configuration loader: forwards the frame stream one cycle late,
// captures a matching payload into a shadow register and applies it on commit.
module sb_cfg_loader #(
  parameter int unsigned CFG_SIZE = 128,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned ID       = 7,
  parameter int unsigned LANES    = 1
) (
  input  logic                clk,
  input  logic                crst_n,
  input  logic                cfg_in_start,
  input  logic [LANES-1:0]    cfg_bit_in,
  input  logic                cfg_commit,
  output logic                cfg_out_start,
  output logic [LANES-1:0]    cfg_bit_out,
  output logic [CFG_SIZE-1:0] cfg_value,
  output logic                cfg_pending,
  output logic                cfg_busy
);

  localparam int unsigned HDR_BEATS = ID_WIDTH / LANES;
  localparam int unsigned PAY_BEATS = CFG_SIZE / LANES;
  localparam int unsigned MAX_BEATS = (HDR_BEATS > PAY_BEATS) ? HDR_BEATS : PAY_BEATS;
  localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [CNT_W-1:0]    HDR_LAST = CNT_W'(HDR_BEATS - 1);
  localparam logic [CNT_W-1:0]    PAY_LAST = CNT_W'(PAY_BEATS - 1);
  localparam logic [ID_WIDTH-1:0] ID_VEC   = ID_WIDTH'(ID);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SKIP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                match_q, match_d;
  logic [CFG_SIZE-1:0] shadow_q, shadow_d;
  logic [CFG_SIZE-1:0] value_q, value_d;
  logic                pending_q, pending_d;
  logic                busy_q, busy_d;
  logic                out_start_q;
  logic [LANES-1:0]    bit_out_q;

  logic [LANES-1:0]    id_beat;
  logic                hdr_match;
  logic [CFG_SIZE-1:0] shadow_next;

  // Header is checked beat by beat against the matching slice of ID.
  assign id_beat   = LANES'(ID_VEC >> (32'(cnt_q) * LANES));
  assign hdr_match = (cfg_bit_in == id_beat) && ((cnt_q == '0) || match_q);

  // New beat enters at the top so the first beat ends up in the LSBs.
  if (CFG_SIZE > LANES) begin : g_shift
    assign shadow_next = {cfg_bit_in, shadow_q[CFG_SIZE-1:LANES]};
  end else begin : g_single
    assign shadow_next = cfg_bit_in;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    shadow_d  = shadow_q;
    value_d   = value_q;
    pending_d = pending_q;

    if (cfg_commit && pending_q && (state_q != ST_LOAD)) begin
      value_d   = shadow_q;
      pending_d = 1'b0;
    end

    if (cfg_in_start) begin
      state_d = ST_HDR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HDR: begin
          match_d = hdr_match;
          if (cnt_q == HDR_LAST) begin
            cnt_d   = '0;
            state_d = hdr_match ? ST_LOAD : ST_SKIP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOAD: begin
          shadow_d = shadow_next;
          if (cnt_q == '0) begin
            pending_d = 1'b0;
          end
          if (cnt_q == PAY_LAST) begin
            cnt_d     = '0;
            state_d   = ST_IDLE;
            pending_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SKIP: begin
          if (cnt_q == PAY_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      shadow_q    <= '0;
      value_q     <= '0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_start_q <= 1'b0;
      bit_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      shadow_q    <= shadow_d;
      value_q     <= value_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      out_start_q <= cfg_in_start;
      bit_out_q   <= cfg_bit_in;
    end
  end

  assign cfg_out_start = out_start_q;
  assign cfg_bit_out   = bit_out_q;
  assign cfg_value     = value_q;
  assign cfg_pending   = pending_q;
  assign cfg_busy      = busy_q;

endmodule
